// File: rtl/gpu_pkg.sv
// Shared GPU types: framebuffer defaults, pixel stream record and writer FSM states.
package gpu_pkg;
  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int COORD_W       = 9;
  localparam int COLOR_W       = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_CLEAR
  } wr_state_e;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel records; head is presented combinationally on dout_o.
module pixel_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  pixel_t                 din_i,
  output pixel_t                 dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  pixel_t         mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [PW:0]    cnt_q;
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  // Push is refused when full even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/pixel_writer.sv
// Framebuffer write engine: clips and queues incoming pixels, linearises them into
// single req/ack writes, and runs a full-screen clear sweep on request.
module pixel_writer
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH   = FB_WIDTH_DEF,
  parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 17
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COLOR_W-1:0] pixel_color,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we,
  input  logic               fb_ack,
  output logic               busy,
  output logic [15:0]        clip_count
);
  localparam logic [ADDR_W-1:0] FBW_A  = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] FBH_A  = ADDR_W'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FB_WIDTH*FB_HEIGHT - 1);

  wr_state_e             state_q, state_d;
  pixel_t                hold_q, hold_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [COLOR_W-1:0]    data_q, data_d;
  logic [15:0]           clip_q;

  pixel_t                fifo_head, fifo_in;
  logic                  fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic                  accept, in_range;

  assign pixel_ready = !fifo_full;
  assign accept      = pixel_valid && pixel_ready;
  assign in_range    = (ADDR_W'(pixel_x) < FBW_A) && (ADDR_W'(pixel_y) < FBH_A);
  assign fifo_push   = accept && in_range;
  assign fifo_in     = '{x: pixel_x, y: pixel_y, color: pixel_color};

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_in),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_q <= '0;
    end else if (accept && !in_range && clip_q != 16'hFFFF) begin
      clip_q <= clip_q + 16'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          addr_d  = '0;
          data_d  = clear_color;
          state_d = ST_CLEAR;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        addr_d  = ADDR_W'(hold_q.y) * FBW_A + ADDR_W'(hold_q.x);
        data_d  = hold_q.color;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (fb_ack) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        // The address register doubles as the sweep counter.
        if (fb_ack) begin
          if (addr_q == LAST_A) state_d = ST_IDLE;
          else                  addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign fb_we      = (state_q == ST_WRITE) || (state_q == ST_CLEAR);
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_cnt != '0);
  assign clip_count = clip_q;
endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: single write, clipping, backpressure, ack stall,
// full clear sweep and reset during a clear.
module tb_pixel_writer;
  logic        clk, reset_n;
  logic [8:0]  pixel_x, pixel_y;
  logic [7:0]  pixel_color, clear_color;
  logic        pixel_valid, pixel_ready, clear_start;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we, fb_ack, busy;
  logic [15:0] clip_count;

  int tests = 0;
  int fails = 0;

  pixel_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_ack      (fb_ack),
    .busy        (busy),
    .clip_count  (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_px(input logic v, input int x, input int y, input int c);
    pixel_valid = v;
    pixel_x     = 9'(x);
    pixel_y     = 9'(y);
    pixel_color = 8'(c);
  endtask

  initial begin : stim
    logic [16:0] waddr [$];
    logic [7:0]  wdata [$];
    int bad;
    int hit;

    reset_n = 1'b0; pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0; pixel_color = '0;
    clear_start = 1'b0; clear_color = '0; fb_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    chk("rst_ready", 32'(pixel_ready), 32'd1);
    chk("rst_we",    32'(fb_we),       32'd0);
    chk("rst_addr",  32'(fb_addr),     32'd0);
    chk("rst_data",  32'(fb_data),     32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_clip",  32'(clip_count),  32'd0);

    // Single pixel (10,5) -> 5*320+10 = 1610
    fb_ack = 1'b1;
    drive_px(1'b1, 10, 5, 8'h3C);
    tick(); drive_px(1'b0, 0, 0, 0);
    chk("single_we_e0", 32'(fb_we), 32'd0);
    chk("single_busy",  32'(busy),  32'd1);
    tick();
    chk("single_we_e1", 32'(fb_we), 32'd0);
    tick();
    chk("single_we_e2", 32'(fb_we),   32'd1);
    chk("single_addr",  32'(fb_addr), 32'd1610);
    chk("single_data",  32'(fb_data), 32'h3C);
    tick();
    chk("single_we_e3", 32'(fb_we), 32'd0);
    chk("single_idle",  32'(busy),  32'd0);

    // Clipping
    drive_px(1'b1, 320, 0, 8'h11);
    tick();
    chk("clip_ready1", 32'(pixel_ready), 32'd1);
    drive_px(1'b1, 0, 240, 8'h22);
    tick(); drive_px(1'b0, 0, 0, 0);
    chk("clip_ready2", 32'(pixel_ready), 32'd1);
    chk("clip_count",  32'(clip_count),  32'd2);
    chk("clip_busy",   32'(busy),        32'd0);
    tick();
    chk("clip_we", 32'(fb_we), 32'd0);

    // Backpressure: five pixels (3i,2) with ack low -> four queued, one held
    fb_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_px(1'b1, 3*i, 2, 8'h10 + i);
      tick();
    end
    drive_px(1'b0, 0, 0, 0);
    chk("bp_ready_low", 32'(pixel_ready), 32'd0);
    chk("bp_we_held",   32'(fb_we),       32'd1);
    chk("bp_addr_held", 32'(fb_addr),     32'd640);
    fb_ack = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (fb_we) begin
        waddr.push_back(fb_addr);
        wdata.push_back(fb_data);
      end
      tick();
    end
    chk("bp_nwrites", 32'(waddr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < waddr.size()) begin
        chk($sformatf("bp_addr%0d", i), 32'(waddr[i]), 32'(640 + 3*i));
        chk($sformatf("bp_data%0d", i), 32'(wdata[i]), 32'(8'h10 + i));
      end
    end
    chk("bp_idle", 32'(busy), 32'd0);

    // Ack stall: (7,7) -> 2247, held 7 cycles
    fb_ack = 1'b0;
    drive_px(1'b1, 7, 7, 8'hA5);
    tick(); drive_px(1'b0, 0, 0, 0);
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("stall%0d", i), {14'd0, fb_we, fb_addr}, {14'd0, 1'b1, 17'd2247});
      chk($sformatf("stall_data%0d", i), 32'(fb_data), 32'hA5);
      tick();
    end
    chk("stall_still", 32'(fb_we), 32'd1);
    fb_ack = 1'b1;
    tick();
    chk("stall_done", 32'(fb_we), 32'd0);
    tick();
    chk("stall_single", 32'(fb_we), 32'd0);

    // Full clear with a pixel (3,4) -> 1283 pushed mid-sweep
    clear_color = 8'h00;
    clear_start = 1'b1;
    tick(); clear_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 76800; i++) begin
      if (!(fb_we === 1'b1 && fb_addr === 17'(i) && fb_data === 8'h00)) bad++;
      if (i == 1000) drive_px(1'b1, 3, 4, 8'h77);
      if (i == 1001) drive_px(1'b0, 0, 0, 0);
      tick();
    end
    chk("clear_sweep_bad", 32'(bad), 32'd0);
    chk("clear_end_we",    32'(fb_we), 32'd0);
    chk("clear_end_busy",  32'(busy),  32'd1);
    tick();
    tick();
    chk("post_clear_we",   32'(fb_we),   32'd1);
    chk("post_clear_addr", 32'(fb_addr), 32'd1283);
    chk("post_clear_data", 32'(fb_data), 32'h77);
    tick();
    chk("post_clear_idle", 32'(busy), 32'd0);

    // Reset in the middle of a clear at address 100
    drive_px(1'b1, 400, 0, 0);
    tick(); drive_px(1'b0, 0, 0, 0);
    chk("pre_rst_clip", 32'(clip_count), 32'd3);
    clear_color = 8'hC3;
    clear_start = 1'b1;
    tick(); clear_start = 1'b0;
    hit = 0;
    for (int k = 0; k < 200 && hit == 0; k++) begin
      if (fb_addr == 17'd100) hit = 1;
      else tick();
    end
    chk("clr_reach100", 32'(hit), 32'd1);
    chk("clr_data",     32'(fb_data), 32'hC3);
    reset_n = 1'b0;
    #1;
    chk("midrst_we",   32'(fb_we),      32'd0);
    chk("midrst_busy", 32'(busy),       32'd0);
    chk("midrst_clip", 32'(clip_count), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_idle", 32'(fb_we), 32'd0);
    clear_start = 1'b1;
    tick(); clear_start = 1'b0;
    chk("restart_we",   32'(fb_we),   32'd1);
    chk("restart_addr", 32'(fb_addr), 32'd0);
    tick();
    chk("restart_addr1", 32'(fb_addr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
